// File: rtl/riscv_phase_controller.sv
// rtl/riscv_phase_controller.sv - eight-phase VeriRISC instruction sequencer
//
// Steps every instruction through eight phases and decodes the control
// strobes from (phase, opcode, zero, halted). Opcode HLT parks the
// sequencer in phase 4 until rst.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   opcode  IR opcode: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   zero    accumulator-is-zero flag
//   sel     address mux select (1=PC, 0=IR operand)
//   rd      memory read enable
//   ld_ir   instruction register load
//   inc_pc  program counter increment
//   ld_pc   program counter load from IR address
//   ld_ac   accumulator load
//   wr      memory write strobe
//   data_e  accumulator data bus drive enable
//   halt    processor halted
//   phase   current phase (debug/trace)

module riscv_phase_controller #(
   parameter int OPC_W   = 3,
   parameter int PHASE_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               zero,
   output logic               sel,
   output logic               rd,
   output logic               ld_ir,
   output logic               inc_pc,
   output logic               ld_pc,
   output logic               ld_ac,
   output logic               wr,
   output logic               data_e,
   output logic               halt,
   output logic [PHASE_W-1:0] phase
);

   localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

   localparam logic [PHASE_W-1:0] PH_INST_ADDR  = PHASE_W'(0);
   localparam logic [PHASE_W-1:0] PH_INST_FETCH = PHASE_W'(1);
   localparam logic [PHASE_W-1:0] PH_INST_LOAD  = PHASE_W'(2);
   localparam logic [PHASE_W-1:0] PH_IDLE       = PHASE_W'(3);
   localparam logic [PHASE_W-1:0] PH_OP_ADDR    = PHASE_W'(4);
   localparam logic [PHASE_W-1:0] PH_OP_FETCH   = PHASE_W'(5);
   localparam logic [PHASE_W-1:0] PH_ALU_OP     = PHASE_W'(6);
   localparam logic [PHASE_W-1:0] PH_STORE      = PHASE_W'(7);

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               halted_q, halted_d;

   logic is_hlt, is_skz, is_sto, is_jmp, aluop;

   assign is_hlt = (opcode == OP_HLT);
   assign is_skz = (opcode == OP_SKZ);
   assign is_sto = (opcode == OP_STO);
   assign is_jmp = (opcode == OP_JMP);
   assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Phase advance; HLT seen in OP_ADDR latches halted and freezes the phase.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (phase_q == PH_OP_ADDR && is_hlt) begin
            halted_d = 1'b1;
         end else begin
            phase_d = phase_q + PHASE_W'(1);
         end
      end
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      if (halted_q) begin
         sel  = 1'b1;
         halt = 1'b1;
      end else begin
         unique case (phase_q)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               // HLT is flagged here a cycle before halted_q takes over.
               halt   = is_hlt;
               inc_pc = !is_hlt;
            end
            PH_OP_FETCH: begin
               rd = aluop;
            end
            PH_ALU_OP: begin
               // SKZ and JMP are distinct opcodes, so inc_pc/ld_pc never overlap.
               rd     = aluop;
               inc_pc = is_skz && zero;
               ld_pc  = is_jmp;
               data_e = is_sto;
            end
            PH_STORE: begin
               rd     = aluop;
               ld_ac  = aluop;
               ld_pc  = is_jmp;
               wr     = is_sto;
               data_e = is_sto;
            end
            default: ;
         endcase
      end
   end

   assign phase = phase_q;

endmodule

// File: tb/tb_riscv_phase_controller.sv
// tb/tb_riscv_phase_controller.sv - self-checking bench for riscv_phase_controller

module tb_riscv_phase_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = 3'd2;
   logic       zero = 1'b0;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   // Reference state
   int m_phase = 0;
   bit m_halted = 1'b0;

   riscv_phase_controller #(.OPC_W(3), .PHASE_W(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
      .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
   );

   always #5 clk = ~clk;

   // Expected strobes {halt,sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e},
   // built from per-opcode sets of active phases.
   function automatic logic [8:0] expect_out(int ph, int op, bit z, bit hlt);
      logic [7:0] m_sel, m_rd, m_ir, m_inc, m_ldpc, m_ac, m_wr, m_de;
      bit alu;
      logic [8:0] r;
      if (hlt) return 9'b110000000;
      alu    = (op >= 2 && op <= 5);
      m_sel  = 8'b0000_1111;
      m_rd   = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
      m_ir   = 8'b0000_1100;
      m_inc  = (op != 0 ? 8'b0001_0000 : 8'h00) | ((op == 1 && z) ? 8'b0100_0000 : 8'h00);
      m_ldpc = (op == 7) ? 8'b1100_0000 : 8'h00;
      m_ac   = alu ? 8'b1000_0000 : 8'h00;
      m_wr   = (op == 6) ? 8'b1000_0000 : 8'h00;
      m_de   = (op == 6) ? 8'b1100_0000 : 8'h00;
      r = {(ph == 4 && op == 0), m_sel[ph], m_rd[ph], m_ir[ph], m_inc[ph],
           m_ldpc[ph], m_ac[ph], m_wr[ph], m_de[ph]};
      return r;
   endfunction

   task automatic check_now(input string tag);
      logic [8:0] exp_o, obs_o;
      logic [2:0] exp_ph;
      exp_o  = expect_out(m_phase, int'(opcode), zero, m_halted);
      obs_o  = {halt, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
      exp_ph = 3'(m_phase);
      checks++;
      assert (obs_o === exp_o) else begin
         errors++;
         $error("FAIL %s strobes ph=%0d op=%0d observed %b expected %b", tag, m_phase, opcode, obs_o, exp_o);
      end
      checks++;
      assert (phase === exp_ph) else begin
         errors++;
         $error("FAIL %s phase observed %0d expected %0d", tag, phase, exp_ph);
      end
      checks++;
      assert ((ld_pc & inc_pc) === 1'b0) else begin
         errors++;
         $error("FAIL %s ld_pc_inc_pc observed %b expected 0", tag, ld_pc & inc_pc);
      end
   endtask

   // Drive inputs, check the combinational decode, then take one clock edge.
   task automatic cyc(input logic [2:0] op, input logic z, input string tag);
      opcode = op;
      zero   = z;
      #1;
      check_now(tag);
      @(posedge clk);
      if (!m_halted) begin
         if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
         else m_phase = (m_phase + 1) % 8;
      end
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      m_phase  = 0;
      m_halted = 1'b0;
      check_now(tag);
      @(posedge clk);
      #1;
      check_now(tag);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      @(posedge clk);
      #1;
      do_reset("reset");

      // ADD instruction plus wrap back to phase 0
      for (int i = 0; i < 9; i++) cyc(3'd2, 1'b0, "add");
      // STO, SKZ with zero, SKZ without zero, JMP
      for (int i = 0; i < 7; i++) cyc(3'd6, 1'b0, "sto");
      for (int i = 0; i < 8; i++) cyc(3'd1, 1'b1, "skz_z1");
      for (int i = 0; i < 8; i++) cyc(3'd1, 1'b0, "skz_z0");
      for (int i = 0; i < 8; i++) cyc(3'd7, 1'b1, "jmp");

      // HLT parks at phase 4; later opcode/zero changes ignored
      for (int i = 0; i < 5; i++) cyc(3'd0, 1'b0, "hlt");
      for (int i = 0; i < 22; i++) cyc(3'($urandom_range(0, 7)), 1'($urandom), "halted");
      do_reset("hlt_reset");
      for (int i = 0; i < 10; i++) cyc(3'd2, 1'b0, "resume");

      // Async reset in the middle of phase 6 of a STO
      while (m_phase != 6) cyc(3'd6, 1'b0, "to_ph6");
      opcode = 3'd6;
      #1;
      check_now("sto_ph6");
      #2;
      rst = 1'b1;
      m_phase  = 0;
      m_halted = 1'b0;
      #1;
      check_now("async_rst");
      @(posedge clk);
      #1;
      check_now("async_rst_hold");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(3'd6, 1'b0, "after_rst");

      // Randomised opcodes and zero, with occasional HLT and reset recovery
      for (int i = 0; i < 400; i++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 24) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         cyc(op, 1'($urandom), "random");
         if (m_halted && $urandom_range(0, 5) == 0) do_reset("random_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
